// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator: default widths and FSM state type.
package mac_pkg;

    // Default accumulator/result width (legal 9..32) and beat-counter width.
    localparam int unsigned ACC_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    // Width of one product beat from the 4x4 wallace_tree: {c_8, s[7:0]}.
    localparam int unsigned PROD_W = 9;

    // ACCUM: collecting beats; DONE: holding a finished result for the consumer.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } mac_state_t;

endpackage

// File: rtl/acc_ripple_adder.sv
// ACC_W-bit ripple-carry adder built from full_adder cells, carry-in tied to 0.
// Provides the accumulator sum and the carry out used for the sticky overflow.
module acc_ripple_adder #(
    parameter int unsigned ACC_W = mac_pkg::ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic [ACC_W:0] carry;

    assign carry[0] = 1'b0;
    assign cout     = carry[ACC_W];

    for (genvar i = 0; i < ACC_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the accumulator ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums a burst of 9-bit products (valid/ready beats ending
// with in_last) and presents sum, saturating beat count and sticky overflow on a
// valid/ready result port until the consumer takes them.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mac_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_carry;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             handoff;

    // Zero-extend the product into the accumulator width.
    assign operand = ACC_W'(in_prod);

    acc_ripple_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a    (acc_q),
        .b    (operand),
        .sum  (acc_sum),
        .cout (acc_carry)
    );

    // Handshake strobes and saturating beat increment; ready/valid depend on state only.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        handoff   = out_valid && out_ready;
        cnt_next  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state: close the burst on an accepted last beat, reopen on result handoff.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (accept && in_last) state_d = DONE;
            DONE:    if (handoff)           state_d = ACCUM;
            default:                        state_d = ACCUM;
        endcase
    end

    // State and accumulator registers; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_next;
                ovf_q <= ovf_q | acc_carry;
            end else if (handoff) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    // Result port is the accumulator registers themselves.
    always_comb begin
        out_sum   = acc_q;
        out_count = cnt_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Three instances share one stimulus stream:
// default widths, ACC_W=9 (overflow) and CNT_W=2 (count saturation).
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_prod;
    logic       in_last;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [15:0] a_sum;
    logic [7:0]  a_count;

    logic        b_in_ready, b_out_valid, b_ovf;
    logic [8:0]  b_sum;
    logic [7:0]  b_count;

    logic        c_in_ready, c_out_valid, c_ovf;
    logic [15:0] c_sum;
    logic [1:0]  c_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_sum), .out_count(a_count), .out_ovf(a_ovf)
    );

    product_accumulator #(.ACC_W(9), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_sum), .out_count(b_count), .out_ovf(b_ovf)
    );

    product_accumulator #(.ACC_W(16), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_sum(c_sum), .out_count(c_count), .out_ovf(c_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [8:0] p, input logic last);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_sum", a_sum, 0);
        check("rst_count", a_count, 0);
        check("rst_ovf", a_ovf, 0);

        // Three beats of 225: back-to-back throughput, then one-cycle result
        beat(9'd225, 1'b0);
        check("b225_ready_mid", a_in_ready, 1);
        beat(9'd225, 1'b0);
        beat(9'd225, 1'b1);
        check("b225_valid", a_out_valid, 1);
        check("b225_in_ready", a_in_ready, 0);
        check("b225_sum", a_sum, 675);
        check("b225_count", a_count, 3);
        check("b225_ovf", a_ovf, 0);
        check("b225_w9_sum", b_sum, 163);
        check("b225_w9_ovf", b_ovf, 1);
        check("b225_c2_count", c_count, 3);
        step();
        check("b225_valid_drop", a_out_valid, 0);
        check("b225_ready_back", a_in_ready, 1);
        check("b225_cleared", a_sum, 0);

        // Single zero-valued beat counts
        beat(9'd0, 1'b1);
        check("zero_valid", a_out_valid, 1);
        check("zero_sum", a_sum, 0);
        check("zero_count", a_count, 1);
        step();

        // 300 + 300: wraps at 9 bits
        beat(9'd300, 1'b0);
        beat(9'd300, 1'b1);
        check("w9_sum", b_sum, 88);
        check("w9_ovf", b_ovf, 1);
        check("w16_sum600", a_sum, 600);
        check("w16_ovf600", a_ovf, 0);
        step();
        beat(9'd5, 1'b1);
        check("w9_next_sum", b_sum, 5);
        check("w9_next_ovf", b_ovf, 0);
        check("w9_next_count", b_count, 1);
        step();

        // Bit 8 of the product is summed: 511 + 511
        beat(9'd511, 1'b0);
        beat(9'd511, 1'b1);
        check("b511_sum", a_sum, 1022);
        check("b511_w9_sum", b_sum, 510);
        check("b511_w9_ovf", b_ovf, 1);
        step();

        // Consumer stall: result 42 held, offered beat not consumed
        out_ready = 1'b0;
        beat(9'd42, 1'b1);
        in_valid = 1'b1; in_prod = 9'd9; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", a_out_valid, 1);
            check("stall_sum", a_sum, 42);
            check("stall_in_ready", a_in_ready, 0);
            step();
        end
        check("stall_count", a_count, 1);
        out_ready = 1'b1;
        step();
        check("stall_release", a_out_valid, 0);
        check("stall_release_sum", a_sum, 0);
        step();
        in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
        check("after_stall_valid", a_out_valid, 1);
        check("after_stall_sum", a_sum, 9);
        check("after_stall_count", a_count, 1);
        step();

        // Five beats of 1: count saturates at 3 for CNT_W=2
        for (int i = 0; i < 5; i++) beat(9'd1, i == 4);
        check("sat_c2_count", c_count, 3);
        check("sat_c2_sum", c_sum, 5);
        check("sat_c2_ovf", c_ovf, 0);
        check("sat_a_count", a_count, 5);
        step();

        // Reset mid-burst after two of four beats, with a beat still offered
        beat(9'd100, 1'b0);
        beat(9'd100, 1'b0);
        in_valid = 1'b1; in_prod = 9'd100; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_prod = '0;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_ready", a_in_ready, 1);
        check("mid_rst_sum", a_sum, 0);
        check("mid_rst_count", a_count, 0);
        check("mid_rst_ovf", a_ovf, 0);
        beat(9'd7, 1'b1);
        check("post_rst_sum", a_sum, 7);
        check("post_rst_count", a_count, 1);

        // Reset while a result is pending in DONE
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done_rst_valid", a_out_valid, 0);
        check("done_rst_sum", a_sum, 0);
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential multiply-accumulate back end that sits directly downstream of the combinational 4x4 `wallace_tree` multiplier. It takes each 9-bit product `{c_8, s[7:0]}` as a valid/ready beat and sums a burst of products terminated by `in_last`. It then presents the accumulated sum, beat count and sticky overflow on a valid/ready output port, holding them until the consumer takes them. Typical use is dot products of 4-bit vectors.

## Interface
Parameters:
- `ACC_W`, 16: accumulator/result width; legal range 9..32.
- `CNT_W`, 8: beat-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  9  `{c_8, s[7:0]}` from `wallace_tree`; bit 8 is 0 for legal 4x4 products but is summed anyway.
- `in_last`  in  1  marks the final beat of a burst.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `ACC_W`  accumulated sum, modulo 2^ACC_W.
- `out_count`  out  `CNT_W`  beats in the burst, saturating at 2^CNT_W-1.
- `out_ovf`  out  1  sticky: some addition in the burst carried out of `ACC_W`.

## Operation
State machine with two states:
- `ACCUM`
  - `in_ready`=1, `out_valid`=0.
  - Accept on `in_valid && in_ready`:
    - `acc <= acc + zext(in_prod)`.
    - `cnt <= sat(cnt+1)`.
    - `ovf <= ovf | carry_out`.
  - Accept with `in_last`=1: the update above lands in the output registers, and the state goes to `DONE`.
- `DONE`
  - `out_valid`=1, `in_ready`=0.
  - Outputs are stable while `out_ready`=0.
  - On `out_valid && out_ready`:
    - clear `acc`, `cnt`, `ovf` to 0;
    - go to `ACCUM`.
- Beats presented while `in_ready`=0 are not consumed; the upstream holds `in_prod`/`in_last` until accepted.
- Single-beat burst (first beat has `in_last`): result equals that product, `out_count`=1.
- Zero-valued products count as beats.
- `out_sum`, `out_count`, `out_ovf` are register outputs. They equal the internal `acc`/`cnt`/`ovf` and are meaningful only while `out_valid`=1.
- Counter saturation: at 2^CNT_W-1 the counter stays put. It does not affect `out_ovf`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0; state `ACCUM`.
- Reset mid-burst or in `DONE` discards partial and pending results. It takes effect on the next edge and overrides all handshakes.
- Throughput: one beat per cycle in `ACCUM`.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, i.e. it is visible in the following cycle.
- No back-to-back overlap: at least one cycle of `in_ready`=0 between bursts. The minimum burst-to-burst gap is 1 cycle when `out_ready` is held high.
- `in_ready` is a function of state only, with no combinational path from `out_ready`.
- The datapath adder is combinational within one cycle: a 9-bit zero-extended operand into an `ACC_W`-bit sum plus carry out.

## Structure
- Shared package `mac_pkg`:
  - `ACC_W_DEF`, `CNT_W_DEF` constants;
  - state typedef `mac_state_t` {`ACCUM`, `DONE`}.
- Sub-module `acc_ripple_adder`:
  - parameterised `ACC_W`-bit ripple adder of `full_adder` cells, carry-in tied 0;
  - outputs sum and carry out.
- Top-level integration, outside this block: `wallace_tree.s`/`c_8` drive `in_prod`. The operand register stage owns `in_valid`/`in_last`.

## Test plan
- Three beats of 225 (15x15), `in_last` on the third, `out_ready`=1 → `out_sum`=675, `out_count`=3, `out_ovf`=0, `out_valid` one cycle, `in_ready` low that cycle.
- Single beat 0x000 with `in_last` → `out_sum`=0, `out_count`=1.
- `ACC_W`=9: beats 300 and 300 → `out_sum`=88, `out_ovf`=1. A following burst {5} → `out_sum`=5, `out_ovf`=0 (sticky bit cleared on handoff).
- `out_ready` held 0 for 10 cycles after result 42 → `out_valid`, `out_sum`=42 stable, `in_ready`=0, `in_valid` beats not consumed. Releasing `out_ready` → the next burst accumulates from 0.
- `CNT_W`=2: five beats of 1 → `out_count`=3 (saturated), `out_sum`=5.
- `rst` asserted after two of four beats (100+100) → all outputs at reset values. A new burst {7} → `out_sum`=7, `out_count`=1.
